// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline definitions.
//   Bit positions of the 12-bit decoder control bundle, MSB first:
//     [11] RegWrite  [10:9] ResultSrc  [8] MemWrite  [7] Branch
//     [6] ALUSrc  [5:4] ALUOp  [3] RegWriteF  [2] MemSrc  [1] DSrc  [0] spare (0)
//   RESSRC_MEM is the ResultSrc encoding of a load (value arrives from memory).
package pipe_pkg;
    localparam int CTRL_W          = 12;
    localparam int CTRL_REGWRITE   = 11;
    localparam int CTRL_RESSRC_MSB = 10;
    localparam int CTRL_RESSRC_LSB = 9;
    localparam int CTRL_MEMWRITE   = 8;
    localparam int CTRL_BRANCH     = 7;
    localparam int CTRL_ALUSRC     = 6;
    localparam int CTRL_ALUOP_MSB  = 5;
    localparam int CTRL_ALUOP_LSB  = 4;
    localparam int CTRL_REGWRITEF  = 3;
    localparam int CTRL_MEMSRC     = 2;
    localparam int CTRL_DSRC       = 1;
    localparam int CTRL_SPARE      = 0;

    localparam logic [1:0] RESSRC_MEM = 2'b01;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use, stall and flush logic.
//   Inputs : state of the instruction in EX (valid, RegWrite, RegWriteF,
//            ResultSrc, rd) and the source usage of the instruction in ID.
//            pc_src_e (taken branch from EX), hold_e (EX busy).
//   Outputs: load_use, stall_f, stall_d, flush_d.
import pipe_pkg::*;

module hazard_detect #(
    parameter int RAW = 5
) (
    input  logic           valid_e,
    input  logic           regwrite_e,
    input  logic           regwrite_f_e,
    input  logic [1:0]     ressrc_e,
    input  logic [RAW-1:0] rd_e,
    input  logic [RAW-1:0] rs1_d,
    input  logic [RAW-1:0] rs2_d,
    input  logic           rs1_f_d,
    input  logic           rs2_f_d,
    input  logic           rs1_use_d,
    input  logic           rs2_use_d,
    input  logic           pc_src_e,
    input  logic           hold_e,
    output logic           load_use,
    output logic           stall_f,
    output logic           stall_d,
    output logic           flush_d
);
    logic hit1;
    logic hit2;
    logic dest_ok;

    // Integer x0 is hard-wired so it never hazards; FP f0 is a real register.
    assign dest_ok = regwrite_f_e | (rd_e != '0);

    // A source only matches a destination in the same register file.
    assign hit1 = rs1_use_d & (rs1_d == rd_e) & (rs1_f_d == regwrite_f_e) & dest_ok;
    assign hit2 = rs2_use_d & (rs2_d == rd_e) & (rs2_f_d == regwrite_f_e) & dest_ok;

    assign load_use = valid_e & (ressrc_e == RESSRC_MEM)
                    & (regwrite_e | regwrite_f_e) & (hit1 | hit2);

    // A taken branch squashes the dependent instruction, so it cancels the
    // load-use stall. A hold freezes everything and defers the flush; the
    // branch unit re-asserts pc_src_e once the hold drops.
    assign flush_d = pc_src_e & ~hold_e;
    assign stall_f = hold_e | (load_use & ~pc_src_e);
    assign stall_d = stall_f;
endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with hazard control.
//   Captures decoder control and operands each cycle and presents them to EX
//   one clock later. A bubble (ctrl 0, valid_e 0) is loaded on a taken branch
//   or a load-use hazard; hold_e freezes the whole EX slot.
//   Ports: clk, reset (sync, active high); *_d decode-stage inputs;
//          pc_src_e, hold_e from EX; *_e registered outputs, valid_e;
//          stall_f, stall_d, flush_d to the front end.
//   valid_d/valid_e qualify the slot: 0 means the contents are a bubble and
//   must have no architectural effect.
//   Optional macro ID_EX_HAZARD_STATS_EN adds saturating 32-bit counters
//   stall_cnt (load-use stall cycles) and flush_cnt (flush cycles).
import pipe_pkg::*;

module id_ex_stage_reg #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   imm_d,
    input  logic [RAW-1:0]    rs1_d,
    input  logic [RAW-1:0]    rs2_d,
    input  logic [RAW-1:0]    rd_d,
    input  logic              rs1_f_d,
    input  logic              rs2_f_d,
    input  logic              rs1_use_d,
    input  logic              rs2_use_d,
    input  logic [2:0]        funct3_d,
    input  logic              funct7b5_d,
    input  logic              pc_src_e,
    input  logic              hold_e,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [XLEN-1:0]   rd1_e,
    output logic [XLEN-1:0]   rd2_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [RAW-1:0]    rs1_e,
    output logic [RAW-1:0]    rs2_e,
    output logic [RAW-1:0]    rd_e,
    output logic [2:0]        funct3_e,
    output logic              funct7b5_e,
    output logic              valid_e,
`ifdef ID_EX_HAZARD_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d
);
    logic load_use;
    logic rd_is_f_e;

    // Destination file of the instruction in EX.
    assign rd_is_f_e = ctrl_e[CTRL_REGWRITEF];

    hazard_detect #(.RAW(RAW)) u_hazard (
        .valid_e      (valid_e),
        .regwrite_e   (ctrl_e[CTRL_REGWRITE]),
        .regwrite_f_e (rd_is_f_e),
        .ressrc_e     (ctrl_e[CTRL_RESSRC_MSB:CTRL_RESSRC_LSB]),
        .rd_e         (rd_e),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rs1_f_d      (rs1_f_d),
        .rs2_f_d      (rs2_f_d),
        .rs1_use_d    (rs1_use_d),
        .rs2_use_d    (rs2_use_d),
        .pc_src_e     (pc_src_e),
        .hold_e       (hold_e),
        .load_use     (load_use),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_e     <= '0;
            valid_e    <= 1'b0;
            rd1_e      <= '0;
            rd2_e      <= '0;
            pc_e       <= '0;
            imm_e      <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
            funct3_e   <= '0;
            funct7b5_e <= 1'b0;
        end else if (!hold_e) begin
            // Data fields always follow D; on a bubble they are don't-care
            // because ctrl and valid are cleared.
            rd1_e      <= rd1_d;
            rd2_e      <= rd2_d;
            pc_e       <= pc_d;
            imm_e      <= imm_d;
            rs1_e      <= rs1_d;
            rs2_e      <= rs2_d;
            rd_e       <= rd_d;
            funct3_e   <= funct3_d;
            funct7b5_e <= funct7b5_d;
            if (pc_src_e || load_use) begin
                ctrl_e  <= '0;
                valid_e <= 1'b0;
            end else begin
                ctrl_e  <= ctrl_d;
                valid_e <= valid_d;
            end
        end
    end

`ifdef ID_EX_HAZARD_STATS_EN
    logic stall_inc;
    assign stall_inc = load_use & ~pc_src_e & ~hold_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (flush_d && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed self-checking bench for id_ex_stage_reg.
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns after.
// With ID_EX_HAZARD_STATS_EN defined the counter ports are also exercised.
module tb_id_ex_stage_reg;
    // Control bundles (bit layout from pipe_pkg)
    localparam logic [11:0] C_LW   = 12'hA40; // RegWrite, ResSrc=01, ALUSrc
    localparam logic [11:0] C_ADD  = 12'h820; // RegWrite, ALUOp=10
    localparam logic [11:0] C_FLW  = 12'h248; // RegWriteF, ResSrc=01, ALUSrc
    localparam logic [11:0] C_FADD = 12'h00A; // RegWriteF, DSrc

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_d;
    logic [11:0] ctrl_d;
    logic [31:0] rd1_d, rd2_d, pc_d, imm_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic        rs1_f_d, rs2_f_d, rs1_use_d, rs2_use_d;
    logic [2:0]  funct3_d;
    logic        funct7b5_d;
    logic        pc_src_e, hold_e;
    logic [11:0] ctrl_e;
    logic [31:0] rd1_e, rd2_e, pc_e, imm_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic [2:0]  funct3_e;
    logic        funct7b5_e, valid_e, stall_f, stall_d, flush_d;
`ifdef ID_EX_HAZARD_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, required done by 200000ns");
        $fatal(1, "watchdog");
    end

    id_ex_stage_reg dut (
        .clk(clk), .reset(reset), .valid_d(valid_d), .ctrl_d(ctrl_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d), .imm_d(imm_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .rs1_f_d(rs1_f_d), .rs2_f_d(rs2_f_d),
        .rs1_use_d(rs1_use_d), .rs2_use_d(rs2_use_d),
        .funct3_d(funct3_d), .funct7b5_d(funct7b5_d),
        .pc_src_e(pc_src_e), .hold_e(hold_e),
        .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .imm_e(imm_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .funct3_e(funct3_e), .funct7b5_e(funct7b5_e), .valid_e(valid_e),
`ifdef ID_EX_HAZARD_STATS_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Data fields are a pattern of rd so the captured copy is easy to predict:
    // rd1=A000_00rd, rd2=B000_00rd, pc=1000+4*rd, imm=FFFF_FF00|rd,
    // funct3=rd[2:0], funct7b5=rd[0].
    task automatic drive_d(input logic v, input logic [11:0] c,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                           input logic f1, input logic f2, input logic u1, input logic u2);
        valid_d    = v;
        ctrl_d     = c;
        rs1_d      = s1;
        rs2_d      = s2;
        rd_d       = d;
        rs1_f_d    = f1;
        rs2_f_d    = f2;
        rs1_use_d  = u1;
        rs2_use_d  = u2;
        rd1_d      = 32'hA000_0000 | {27'd0, d};
        rd2_d      = 32'hB000_0000 | {27'd0, d};
        pc_d       = 32'h0000_1000 + {25'd0, d, 2'b00};
        imm_d      = 32'hFFFF_FF00 | {27'd0, d};
        funct3_d   = d[2:0];
        funct7b5_d = d[0];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; pc_src_e = 1'b0; hold_e = 1'b0;
        drive_d(1'b1, 12'hFFF, 5'd3, 5'd4, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1);
        tick(); tick();
        settle();
        check("rst_ctrl_e", {20'd0, ctrl_e}, 32'h0);
        check("rst_valid_e", {31'd0, valid_e}, 32'h0);
        check("rst_rd1_e", rd1_e, 32'h0);
        check("rst_pc_e", pc_e, 32'h0);
        check("rst_rd_e", {27'd0, rd_e}, 32'h0);
        check("rst_stall_f", {31'd0, stall_f}, 32'h0);
        check("rst_stall_d", {31'd0, stall_d}, 32'h0);
        check("rst_flush_d", {31'd0, flush_d}, 32'h0);
`ifdef ID_EX_HAZARD_STATS_EN
        check("rst_stall_cnt", stall_cnt, 32'h0);
        check("rst_flush_cnt", flush_cnt, 32'h0);
`endif

        // ---- integer load-use: lw x5 then add x7, x5, x6 ----
        reset = 1'b0;
        drive_d(1'b1, C_LW, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); settle();
        check("lw_ctrl_e", {20'd0, ctrl_e}, 32'hA40);
        check("lw_valid_e", {31'd0, valid_e}, 32'h1);
        check("lw_rd_e", {27'd0, rd_e}, 32'd5);
        drive_d(1'b1, C_ADD, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        check("lu_stall_f", {31'd0, stall_f}, 32'h1);
        check("lu_stall_d", {31'd0, stall_d}, 32'h1);
        check("lu_flush_d", {31'd0, flush_d}, 32'h0);
        tick(); settle();
        check("lu_bubble_valid", {31'd0, valid_e}, 32'h0);
        check("lu_bubble_ctrl", {20'd0, ctrl_e}, 32'h0);
        check("lu_one_cycle", {31'd0, stall_f}, 32'h0);
        tick(); settle();
        check("add_ctrl_e", {20'd0, ctrl_e}, 32'h820);
        check("add_valid_e", {31'd0, valid_e}, 32'h1);
        check("add_rd_e", {27'd0, rd_e}, 32'd7);
        check("add_rs1_e", {27'd0, rs1_e}, 32'd5);
        check("add_rs2_e", {27'd0, rs2_e}, 32'd6);
        check("add_rd1_e", rd1_e, 32'hA000_0007);
        check("add_rd2_e", rd2_e, 32'hB000_0007);
        check("add_pc_e", pc_e, 32'h0000_101C);
        check("add_imm_e", imm_e, 32'hFFFF_FF07);
        check("add_funct3_e", {29'd0, funct3_e}, 32'd7);
        check("add_funct7b5_e", {31'd0, funct7b5_e}, 32'd1);

        // ---- register-file discrimination: flw f5 in E ----
        drive_d(1'b1, C_FLW, 5'd2, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive_d(1'b1, C_ADD, 5'd5, 5'd1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        check("flw_int_reader", {31'd0, stall_f}, 32'h0);
        drive_d(1'b1, C_FADD, 5'd5, 5'd1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1);
        settle();
        check("flw_fp_reader", {31'd0, stall_f}, 32'h1);
        tick(); settle();
        check("flw_bubble", {31'd0, valid_e}, 32'h0);

        // ---- lw x0 never hazards ----
        drive_d(1'b1, C_LW, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive_d(1'b1, C_ADD, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        check("x0_no_stall", {31'd0, stall_d}, 32'h0);

        // ---- rs2 path and the use qualifier: lw x9 ----
        drive_d(1'b1, C_LW, 5'd1, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive_d(1'b1, C_ADD, 5'd3, 5'd9, 5'd10, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        check("rs2_hit", {31'd0, stall_f}, 32'h1);
        rs2_use_d = 1'b0;
        settle();
        check("rs2_unused", {31'd0, stall_f}, 32'h0);

        // ---- branch flush overrides load-use ----
        drive_d(1'b1, C_ADD, 5'd9, 5'd0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0);
        pc_src_e = 1'b1;
        settle();
        check("br_flush_d", {31'd0, flush_d}, 32'h1);
        check("br_stall_f", {31'd0, stall_f}, 32'h0);
        tick();
        pc_src_e = 1'b0;
        settle();
        check("br_bubble_valid", {31'd0, valid_e}, 32'h0);
        check("br_bubble_ctrl", {20'd0, ctrl_e}, 32'h0);

        // ---- EX hold with a pending branch ----
        drive_d(1'b1, C_ADD, 5'd1, 5'd2, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive_d(1'b1, C_LW, 5'd3, 5'd4, 5'd13, 1'b0, 1'b0, 1'b1, 1'b1);
        hold_e = 1'b1; pc_src_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("hold_stall_f", {31'd0, stall_f}, 32'h1);
            check("hold_flush_d", {31'd0, flush_d}, 32'h0);
            tick();
            check("hold_ctrl_e", {20'd0, ctrl_e}, 32'h820);
            check("hold_rd_e", {27'd0, rd_e}, 32'd12);
            check("hold_rd1_e", rd1_e, 32'hA000_000C);
            check("hold_valid_e", {31'd0, valid_e}, 32'h1);
        end
        hold_e = 1'b0;
        settle();
        check("release_flush_d", {31'd0, flush_d}, 32'h1);
        check("release_stall_f", {31'd0, stall_f}, 32'h0);
        tick();
        pc_src_e = 1'b0;
        settle();
        check("release_flush_once", {31'd0, flush_d}, 32'h0);
        check("release_bubble", {31'd0, valid_e}, 32'h0);

        // ---- reset in the middle of a load-use stall ----
        drive_d(1'b1, C_LW, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive_d(1'b1, C_ADD, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        check("pre_rst_stall", {31'd0, stall_f}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("mid_rst_valid", {31'd0, valid_e}, 32'h0);
        check("mid_rst_ctrl", {20'd0, ctrl_e}, 32'h0);
        check("mid_rst_stall", {31'd0, stall_f}, 32'h0);
        check("mid_rst_flush", {31'd0, flush_d}, 32'h0);

`ifdef ID_EX_HAZARD_STATS_EN
        // ---- counters: 4 load-use stalls, 2 flushes ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_d(1'b1, C_LW, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            drive_d(1'b1, C_ADD, 5'd5, 5'd0, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        drive_d(1'b0, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            pc_src_e = 1'b1;
            tick();
            pc_src_e = 1'b0;
            tick();
        end
        settle();
        check("stats_stall_cnt", stall_cnt, 32'd4);
        check("stats_flush_cnt", flush_cnt, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("stats_rst_stall", stall_cnt, 32'd0);
        check("stats_rst_flush", flush_cnt, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register directly downstream of the main decoder.
- Captures the decoder's control bundle plus decode-stage operands each cycle, and presents them to the execute stage one cycle later.
- Owns load-use hazard detection for the integer and FP register files, bubble insertion, branch flush and external EX hold.

Parameters:
- XLEN, 32, datapath width of operands, PC and immediate
- RAW, 5, register index width

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-high reset
- valid_d  in  1  instruction in ID is real (0 = bubble)
- ctrl_d  in  12  {RegWrite, ResultSrc[1:0], MemWrite, Branch, ALUSrc, ALUOp[1:0], RegWriteF, MemSrc, DSrc, ImmSrc-independent spare=0} from decoder
- rd1_d, rd2_d  in  XLEN  source operands (int or FP file, already muxed)
- pc_d, imm_d  in  XLEN  PC and extended immediate
- rs1_d, rs2_d, rd_d  in  RAW  register indices
- rs1_f_d, rs2_f_d  in  1  source read from FP file
- rs1_use_d, rs2_use_d  in  1  source actually consumed
- funct3_d  in  3; funct7b5_d  in  1
- pc_src_e  in  1  branch taken, resolved in EX
- hold_e  in  1  EX must keep current contents (multi-cycle unit busy)
- ctrl_e, rd1_e, rd2_e, pc_e, imm_e, rs1_e, rs2_e, rd_e, funct3_e, funct7b5_e  out  matching widths  registered copies
- valid_e  out  1  EX slot holds a real instruction
- stall_f, stall_d  out  1  freeze PC and IF/ID
- flush_d  out  1  squash IF/ID

Behaviour:
- Reset, synchronous and active-high, with the clock named clk and the reset named reset:
  - All registered outputs are 0 and valid_e is 0.
  - Combinational outputs therefore evaluate to 0.
- Latency: one clock from D inputs to E outputs.
- rd_is_f_e is derived as ctrl_e.RegWriteF.
- load_use = valid_e & (ResultSrc_e == 2'b01) & (RegWrite_e | RegWriteF_e) & (hit1 | hit2).
  - hitN = rsN_use_d & (rsN_d == rd_e) & (rsN_f_d == RegWriteF_e) & (RegWriteF_e | rd_e != 0).
  - x0 never hazards; f0 does.
- Update priority each clock edge, highest first:
  1. reset
  2. hold_e: all E registers keep their value.
  3. pc_src_e or load_use: E loads a bubble (ctrl 0, valid 0). Data fields may load D values; they are don't-care.
  4. Otherwise: E loads D inputs; valid_e = valid_d.
- flush_d = pc_src_e & ~hold_e.
- stall_f = stall_d = hold_e | (load_use & ~pc_src_e).
  - A taken branch overrides the load-use stall, because the dependent instruction is being squashed.
- Simultaneous hold_e and pc_src_e: hold wins and no flush is issued. The branch re-asserts pc_src_e once the hold releases.
- A bubble in E (valid_e = 0) never generates load_use, pc_src_e is externally gated by valid_e, and no spurious stall follows reset.
- Reset mid-stall: the next cycle is a clean empty E stage and all stall and flush outputs are 0.

Optional Feature:
- Macro: ID_EX_HAZARD_STATS_EN.
- With the macro defined:
  - Adds outputs stall_cnt and flush_cnt, each 32 bits.
  - stall_cnt increments each cycle load_use & ~pc_src_e & ~hold_e.
  - flush_cnt increments each cycle flush_d.
  - Both counters saturate at all-ones and clear on reset.
- Without the macro: the ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the ctrl bundle bit positions as localparams (CTRL_REGWRITE, CTRL_RESSRC_LSB, … CTRL_DSRC), with CTRL_W = 12;
  - RESSRC_MEM = 2'b01.
- Natural sub-module: hazard_detect, the combinational load_use, stall and flush logic, instantiated inside the register block.

Test Plan:
- Reset check: reset held 2 cycles with D driving ctrl all-ones -> all E outputs 0, valid_e = 0, stall_f/stall_d/flush_d = 0.
- Integer load-use: lw x5 in E (ResultSrc 01, RegWrite 1, rd 5); add in D with rs1 = 5 used -> stall_f = stall_d = 1 for exactly 1 cycle, bubble in E (valid_e = 0), add enters E the next cycle.
- Register-file and x0 discrimination:
  - flw f5 in E; integer add in D reading x5 -> no stall.
  - Same with fadd reading f5 -> stall.
  - lw x0 with a consumer of x0 -> no stall.
- Branch flush: pc_src_e = 1 while D has a load-use hit -> flush_d = 1, stall_f = 0, E becomes a bubble next cycle.
- EX hold: hold_e = 1 for 3 cycles with pc_src_e = 1 -> E outputs unchanged, stall_f = 1, flush_d = 0; on release, flush_d = 1 for one cycle.
- Stats (with ID_EX_HAZARD_STATS_EN defined): 4 load-use events plus 2 flushes -> stall_cnt = 4, flush_cnt = 2; reset -> both 0.
